// File: rtl/usb_link_top.sv
// Loopback USB-style link: host byte port -> SYNC/NRZI/bit-stuff transmitter
// -> internal dp/dm line -> receiver (SYNC hunt, NRZI decode, destuff) -> host.
module usb_link_top (
  input  logic       gclk,
  input  logic       reset_l,
  input  logic       cs1_l,
  input  logic       SYN_GEN_LD,
  input  logic       TX_LOAD,
  input  logic [7:0] TX_DATA,
  input  logic       TX_LAST_BYTE,
  input  logic       RX_LOAD,
  output logic       TX_READY_LD,
  output logic [7:0] DATA,
  output logic       RX_READY_LD
);

  typedef enum logic [1:0] {TX_ST_IDLE, TX_ST_SYNC, TX_ST_DATA, TX_ST_EOP} tx_state_e;
  typedef enum logic       {RX_ST_HUNT, RX_ST_DATA} rx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [2:0] MAX_ONES  = 3'd6;

  // Transmit side
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       tx_sh_last_q, tx_sh_last_d;
  logic [2:0] tx_bit_cnt_q, tx_bit_cnt_d;
  logic [2:0] tx_ones_q, tx_ones_d;
  logic [1:0] tx_eop_cnt_q, tx_eop_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_last_q, hold_last_d;
  logic       tx_ready_q, tx_ready_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic       tx_bit;

  // Receive side
  rx_state_e  rx_state_q, rx_state_d;
  logic       rx_dp_q, rx_dm_q;
  logic       rx_prev_q, rx_prev_d;
  logic [7:0] rx_hist_q, rx_hist_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_ones_q, rx_ones_d;
  logic [7:0] data_q, data_d;
  logic       rx_ready_q, rx_ready_d;
  logic       rx_bit;
  logic [7:0] hist_nxt;
  logic [7:0] sh_nxt;

  // TX next state: holding register, byte shifter with stuffing, NRZI line drive, EOP.
  always_comb begin
    // NOTE: every _d gets its default first so no path leaves it unassigned and infers a latch.
    tx_state_d   = tx_state_q;
    tx_sh_d      = tx_sh_q;
    tx_sh_last_d = tx_sh_last_q;
    tx_bit_cnt_d = tx_bit_cnt_q;
    tx_ones_d    = tx_ones_q;
    tx_eop_cnt_d = tx_eop_cnt_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    tx_ready_d   = tx_ready_q;
    dp_d         = dp_q;
    dm_d         = dm_q;
    tx_bit       = 1'b1;

    // The holding register accepts a byte only when empty; the boundary move below
    // only happens when it is full, so the two never collide.
    if (TX_LOAD && !cs1_l && tx_ready_q) begin
      hold_d      = TX_DATA;
      hold_last_d = TX_LAST_BYTE;
      tx_ready_d  = 1'b0;
    end

    case (tx_state_q)
      TX_ST_IDLE: begin
        if (SYN_GEN_LD && !cs1_l) begin
          tx_state_d   = TX_ST_SYNC;
          tx_sh_d      = SYNC_BYTE;
          tx_sh_last_d = 1'b0;
          tx_bit_cnt_d = 3'd0;
          tx_ones_d    = 3'd0;
        end
      end
      TX_ST_SYNC, TX_ST_DATA: begin
        if (tx_ones_q == MAX_ONES) begin
          // Stuffed 0: the shifter holds still for this cycle.
          tx_bit    = 1'b0;
          tx_ones_d = 3'd0;
        end else begin
          tx_bit       = tx_sh_q[0];
          tx_ones_d    = tx_bit ? tx_ones_q + 3'd1 : 3'd0;
          tx_sh_d      = {1'b0, tx_sh_q[7:1]};
          tx_bit_cnt_d = tx_bit_cnt_q + 3'd1;
          if (tx_bit_cnt_q == 3'd7) begin
            if (!tx_sh_last_q && !tx_ready_q) begin
              tx_state_d   = TX_ST_DATA;
              tx_sh_d      = hold_q;
              tx_sh_last_d = hold_last_q;
              tx_ready_d   = 1'b1;
            end else begin
              // Last byte sent, or nothing queued (underrun).
              tx_state_d   = TX_ST_EOP;
              tx_eop_cnt_d = 2'd0;
            end
          end
        end
        // NRZI: a 0 toggles between J and K, a 1 holds the line.
        if (!tx_bit) begin
          dp_d = ~dp_q;
          dm_d = dp_q;
        end
      end
      TX_ST_EOP: begin
        if (tx_eop_cnt_q < 2'd2) begin
          dp_d         = 1'b0;
          dm_d         = 1'b0;
          tx_eop_cnt_d = tx_eop_cnt_q + 2'd1;
        end else begin
          dp_d       = 1'b1;
          dm_d       = 1'b0;
          tx_state_d = TX_ST_IDLE;
        end
      end
      default: tx_state_d = TX_ST_IDLE;
    endcase
  end

  // TX registers; the line idles at J.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      tx_state_q   <= TX_ST_IDLE;
      tx_sh_q      <= '0;
      tx_sh_last_q <= 1'b0;
      tx_bit_cnt_q <= '0;
      tx_ones_q    <= '0;
      tx_eop_cnt_q <= '0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      tx_ready_q   <= 1'b1;
      dp_q         <= 1'b1;
      dm_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      tx_state_q   <= tx_state_d;
      tx_sh_q      <= tx_sh_d;
      tx_sh_last_q <= tx_sh_last_d;
      tx_bit_cnt_q <= tx_bit_cnt_d;
      tx_ones_q    <= tx_ones_d;
      tx_eop_cnt_q <= tx_eop_cnt_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      tx_ready_q   <= tx_ready_d;
      dp_q         <= dp_d;
      dm_q         <= dm_d;
    end
  end

  // RX next state: NRZI decode of the sampled line, SYNC hunt, destuff, byte assembly.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_prev_d  = rx_dp_q;
    rx_hist_d  = rx_hist_q;
    rx_sh_d    = rx_sh_q;
    rx_cnt_d   = rx_cnt_q;
    rx_ones_d  = rx_ones_q;
    data_d     = data_q;
    rx_ready_d = rx_ready_q;
    rx_bit     = (rx_dp_q == rx_prev_q);
    hist_nxt   = {rx_hist_q[6:0], rx_bit};
    sh_nxt     = {rx_bit, rx_sh_q[7:1]};

    if (RX_LOAD && !cs1_l) rx_ready_d = 1'b0;

    if (!rx_dp_q && !rx_dm_q) begin
      // SE0 ends the packet; the J that follows must decode as a 1.
      rx_state_d = RX_ST_HUNT;
      rx_hist_d  = 8'hFF;
      rx_prev_d  = 1'b1;
    end else begin
      case (rx_state_q)
        RX_ST_HUNT: begin
          rx_hist_d = hist_nxt;
          if (hist_nxt == 8'h01) begin
            rx_state_d = RX_ST_DATA;
            rx_cnt_d   = 3'd0;
            rx_ones_d  = 3'd1;  // the SYNC 1 counts toward the stuffing run
          end
        end
        RX_ST_DATA: begin
          if (rx_ones_q == MAX_ONES) begin
            rx_ones_d = 3'd0;
            if (rx_bit) begin
              // Seven 1s in a row is a stuffing error: drop the packet.
              rx_state_d = RX_ST_HUNT;
              rx_hist_d  = 8'hFF;
            end
          end else begin
            rx_ones_d = rx_bit ? rx_ones_q + 3'd1 : 3'd0;
            rx_sh_d   = sh_nxt;
            rx_cnt_d  = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) begin
              data_d     = sh_nxt;
              rx_ready_d = 1'b1;  // a new byte wins over a same-cycle RX_LOAD
            end
          end
        end
        default: rx_state_d = RX_ST_HUNT;
      endcase
    end
  end

  // RX registers, including the line sampling stage.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      rx_state_q <= RX_ST_HUNT;
      rx_dp_q    <= 1'b1;
      rx_dm_q    <= 1'b0;
      rx_prev_q  <= 1'b1;
      rx_hist_q  <= 8'hFF;
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      rx_ones_q  <= '0;
      data_q     <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_dp_q    <= dp_q;
      rx_dm_q    <= dm_q;
      rx_prev_q  <= rx_prev_d;
      rx_hist_q  <= rx_hist_d;
      rx_sh_q    <= rx_sh_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_ones_q  <= rx_ones_d;
      data_q     <= data_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign TX_READY_LD = tx_ready_q;
  assign DATA        = data_q;
  assign RX_READY_LD = rx_ready_q;

endmodule

// File: tb/tb_usb_link_top.sv
// Self-checking bench for usb_link_top: a bit-stream model of each packet gives the
// expected line waveform, byte arrival cycles and received data.
module tb_usb_link_top;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  logic       gclk         = 1'b0;
  logic       reset_l      = 1'b0;
  logic       cs1_l        = 1'b1;
  logic       SYN_GEN_LD   = 1'b0;
  logic       TX_LOAD      = 1'b0;
  logic [7:0] TX_DATA      = 8'h00;
  logic       TX_LAST_BYTE = 1'b0;
  logic       host_rx_load = 1'b0;
  logic       ack_drv      = 1'b0;
  logic       RX_LOAD;
  logic       TX_READY_LD;
  logic [7:0] DATA;
  logic       RX_READY_LD;

  assign RX_LOAD = host_rx_load | ack_drv;

  usb_link_top dut (
    .gclk        (gclk),
    .reset_l     (reset_l),
    .cs1_l       (cs1_l),
    .SYN_GEN_LD  (SYN_GEN_LD),
    .TX_LOAD     (TX_LOAD),
    .TX_DATA     (TX_DATA),
    .TX_LAST_BYTE(TX_LAST_BYTE),
    .RX_LOAD     (RX_LOAD),
    .TX_READY_LD (TX_READY_LD),
    .DATA        (DATA),
    .RX_READY_LD (RX_READY_LD)
  );

  int   cyc       = 0;
  int   n_chk     = 0;
  int   n_bad     = 0;
  int   start_cyc = 0;
  int   cap_n     = 0;
  bit   cap_on    = 1'b0;
  bit   auto_ack  = 1'b1;
  logic rdy_prev  = 1'b0;

  logic [7:0] pkt[$];
  logic [1:0] exp_line[$];
  int         exp_end[$];
  logic [1:0] line_q[$];
  logic [7:0] rx_data_q[$];
  int         rx_cyc_q[$];

  always #5 gclk = ~gclk;

  always @(posedge gclk) cyc <= cyc + 1;

  // Line capture, byte-arrival log and automatic host acknowledge.
  always @(negedge gclk) begin
    if (cap_on && cyc > start_cyc && line_q.size() < cap_n)
      line_q.push_back({dut.dp_q, dut.dm_q});
    if (ack_drv) ack_drv = 1'b0;
    else if (RX_READY_LD && !rdy_prev && auto_ack) ack_drv = 1'b1;
    if (RX_READY_LD && !rdy_prev) begin
      rx_data_q.push_back(DATA);
      rx_cyc_q.push_back(cyc);
    end
    rdy_prev = RX_READY_LD;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected line: SYNC then payload LSB first, a 0 inserted before any bit that
  // follows six 1s, NRZI from J, then SE0 SE0 J.
  task automatic build_model();
    logic       lvl;
    int         ones;
    logic [7:0] by;
    exp_line.delete();
    exp_end.delete();
    lvl  = 1'b1;
    ones = 0;
    for (int b = -1; b < int'(pkt.size()); b++) begin
      if (b < 0) by = 8'h80;
      else       by = pkt[b];
      for (int i = 0; i < 8; i++) begin
        if (ones == 6) begin
          lvl = ~lvl;
          exp_line.push_back({lvl, ~lvl});
          ones = 0;
        end
        if (!by[i]) lvl = ~lvl;
        exp_line.push_back({lvl, ~lvl});
        ones = by[i] ? ones + 1 : 0;
      end
      if (b >= 0) exp_end.push_back(exp_line.size());
    end
    exp_line.push_back(LINE_SE0);
    exp_line.push_back(LINE_SE0);
    exp_line.push_back(LINE_J);
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    TX_DATA      = d;
    TX_LAST_BYTE = last;
    TX_LOAD      = 1'b1;
    @(negedge gclk);
    TX_LOAD      = 1'b0;
    TX_LAST_BYTE = 1'b0;
  endtask

  function automatic int first_se0();
    for (int i = 0; i < int'(line_q.size()); i++)
      if (line_q[i] == LINE_SE0) return i;
    return -1;
  endfunction

  // Sends pkt as one packet; optionally pulses RX_LOAD in the very cycle the first byte lands.
  task automatic run_packet(input string tag, input bit collide);
    int to;
    int n;
    build_model();
    line_q.delete();
    rx_data_q.delete();
    rx_cyc_q.delete();
    cap_n = exp_line.size();
    n     = int'(pkt.size());
    if (n > 0) begin
      load_byte(pkt[0], n == 1);
      check($sformatf("%s hold full", tag), TX_READY_LD, 0);
    end
    start_cyc  = cyc + 1;
    cap_on     = 1'b1;
    SYN_GEN_LD = 1'b1;
    @(negedge gclk);
    SYN_GEN_LD = 1'b0;
    for (int b = 1; b < n; b++) begin
      to = 0;
      while (!TX_READY_LD && to < 40) begin
        @(negedge gclk);
        to++;
      end
      check($sformatf("%s reload %0d", tag, b), TX_READY_LD, 1);
      load_byte(pkt[b], b == n - 1);
    end
    to = 0;
    while (cyc < start_cyc + cap_n + 3 && to < 400) begin
      host_rx_load = (collide && n > 0) ? (cyc == start_cyc + exp_end[0] + 1) : 1'b0;
      @(negedge gclk);
      to++;
    end
    host_rx_load = 1'b0;
    cap_on       = 1'b0;
    check($sformatf("%s line length", tag), line_q.size(), cap_n);
    for (int i = 0; i < int'(line_q.size()) && i < cap_n; i++)
      check($sformatf("%s line[%0d]", tag, i), line_q[i], exp_line[i]);
    if (auto_ack) begin
      check($sformatf("%s byte count", tag), rx_data_q.size(), n);
      for (int k = 0; k < int'(rx_data_q.size()) && k < n; k++) begin
        check($sformatf("%s data[%0d]", tag, k), rx_data_q[k], pkt[k]);
        check($sformatf("%s arrival[%0d]", tag, k), rx_cyc_q[k], start_cyc + exp_end[k] + 2);
      end
      check($sformatf("%s rx acked", tag), RX_READY_LD, 0);
    end
    check($sformatf("%s tx empty", tag), TX_READY_LD, 1);
  endtask

  initial begin
    int         nj;
    int         to;
    int         nb;
    logic [7:0] v;

    // Reset state
    repeat (2) @(negedge gclk);
    check("reset tx_ready", TX_READY_LD, 1);
    check("reset rx_ready", RX_READY_LD, 0);
    check("reset data", DATA, 8'h00);
    check("reset line", {dut.dp_q, dut.dm_q}, LINE_J);
    reset_l = 1'b1;
    @(negedge gclk);
    cs1_l = 1'b0;
    @(negedge gclk);

    // Single byte
    pkt = '{8'hA5};
    run_packet("a5", 1'b0);
    check("a5 bits before eop", first_se0(), 16);

    // Stuffing: the SYNC 1 plus five data 1s force a stuffed 0
    pkt = '{8'hFF};
    run_packet("ff", 1'b0);
    check("ff bits before eop", first_se0(), 17);

    // Back-to-back bytes
    pkt = '{8'h01, 8'h02, 8'h03};
    run_packet("multi", 1'b0);

    // Underrun: nothing loaded
    pkt.delete();
    run_packet("underrun", 1'b0);
    check("underrun bits before eop", first_se0(), 8);
    check("underrun rx_ready", RX_READY_LD, 0);

    // Randomized packets, biased toward FF to exercise stuffing across bytes
    for (int p = 0; p < 8; p++) begin
      pkt.delete();
      nb = int'($urandom_range(1, 4));
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 2) == 0) v = 8'hFF;
        else                           v = 8'($urandom);
        pkt.push_back(v);
      end
      run_packet($sformatf("rand%0d", p), 1'b0);
    end

    // Overflow: two bytes, never acknowledged
    auto_ack = 1'b0;
    pkt = '{8'h3C, 8'hC3};
    run_packet("ovf", 1'b0);
    check("ovf rises", rx_data_q.size(), 1);
    check("ovf data", DATA, 8'hC3);
    check("ovf rx_ready", RX_READY_LD, 1);

    // Chip select gating: every strobe ignored while cs1_l is high
    cs1_l        = 1'b1;
    TX_DATA      = 8'h77;
    TX_LAST_BYTE = 1'b1;
    TX_LOAD      = 1'b1;
    SYN_GEN_LD   = 1'b1;
    host_rx_load = 1'b1;
    @(negedge gclk);
    TX_LOAD      = 1'b0;
    TX_LAST_BYTE = 1'b0;
    SYN_GEN_LD   = 1'b0;
    host_rx_load = 1'b0;
    nj = 0;
    repeat (20) begin
      @(negedge gclk);
      if ({dut.dp_q, dut.dm_q} != LINE_J) nj++;
    end
    check("gate line activity", nj, 0);
    check("gate tx_ready", TX_READY_LD, 1);
    check("gate rx_ready", RX_READY_LD, 1);
    check("gate data", DATA, 8'hC3);
    cs1_l = 1'b0;
    @(negedge gclk);

    // New byte and RX_LOAD in the same cycle: the byte wins
    pkt = '{8'h5A};
    run_packet("collide", 1'b1);
    check("collide rx_ready", RX_READY_LD, 1);
    check("collide data", DATA, 8'h5A);

    // Reset in the middle of a packet
    rx_data_q.delete();
    load_byte(8'h00, 1'b0);
    start_cyc  = cyc + 1;
    SYN_GEN_LD = 1'b1;
    @(negedge gclk);
    SYN_GEN_LD = 1'b0;
    to = 0;
    while (!TX_READY_LD && to < 40) begin
      @(negedge gclk);
      to++;
    end
    check("rst reload", TX_READY_LD, 1);
    load_byte(8'h11, 1'b1);
    to = 0;
    while (cyc < start_cyc + 14 && to < 40) begin
      @(negedge gclk);
      to++;
    end
    check("rst pre tx_ready", TX_READY_LD, 0);
    reset_l = 1'b0;
    #1;
    check("rst tx_ready", TX_READY_LD, 1);
    check("rst rx_ready", RX_READY_LD, 0);
    check("rst data", DATA, 8'h00);
    check("rst line", {dut.dp_q, dut.dm_q}, LINE_J);
    repeat (2) @(negedge gclk);
    reset_l = 1'b1;
    repeat (30) @(negedge gclk);
    check("rst no delivery", rx_data_q.size(), 0);
    check("rst after rx_ready", RX_READY_LD, 0);
    check("rst after line", {dut.dp_q, dut.dm_q}, LINE_J);

    // Link recovers after reset
    auto_ack = 1'b1;
    pkt = '{8'hE7, 8'h7E};
    run_packet("post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
